// File: rtl/jump_lut_pkg.sv
// ---------------------------------------------------------------------------
// jump_lut_pkg
//
// Shared definitions for the jump-target lookup table loader:
//   - DEFAULT_D / DEFAULT_N : default jump-target width and table depth
//   - BYTE_W / PAIR_W       : byte-split helper constants for assembling an
//                             entry from a LO byte followed by a HI byte
//   - lut_state_e           : loader FSM state encoding
//   - joinBytes()           : concatenates HI and LO bytes into a 16-bit pair
//
// Optional feature macro: JUMP_LUT_CHECKSUM_EN (adds the CHK state).
// ---------------------------------------------------------------------------
package jump_lut_pkg;

   localparam int DEFAULT_D = 12;
   localparam int DEFAULT_N = 32;

   localparam int BYTE_W = 8;
   localparam int PAIR_W = 2 * BYTE_W;

   // CHK only exists when the trailing checksum byte is part of the stream.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LO   = 3'd1,
      ST_HI   = 3'd2,
`ifdef JUMP_LUT_CHECKSUM_EN
      ST_CHK  = 3'd3,
`endif
      ST_DONE = 3'd4
   } lut_state_e;

   // Entries arrive little-endian: LO byte first, then HI byte. The caller
   // truncates the returned pair to the target width, which drops the HI
   // byte's unused upper bits.
   function automatic logic [PAIR_W-1:0] joinBytes(input logic [BYTE_W-1:0] hiByte,
                                                    input logic [BYTE_W-1:0] loByte);
      return {hiByte, loByte};
   endfunction

endpackage

// File: rtl/jump_lut_regfile.sv
// ---------------------------------------------------------------------------
// jump_lut_regfile
//
// N x D storage for jump targets. One synchronous write port, one
// combinational read port, asynchronous clear of every entry to 0.
//
// Ports:
//   clk        : clock, writes on rising edge
//   reset      : asynchronous active-high clear of all entries
//   we_i       : write enable
//   wr_addr_i  : write index
//   wr_data_i  : write data
//   rd_addr_i  : read index
//   rd_data_o  : entry at rd_addr_i (old value during a same-cycle write)
// ---------------------------------------------------------------------------
module jump_lut_regfile
   import jump_lut_pkg::*;
#(
   parameter  int D  = DEFAULT_D,
   parameter  int N  = DEFAULT_N,
   localparam int AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [D-1:0]  wr_data_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [D-1:0]  rd_data_o
);

   logic [D-1:0] mem_q [N];

   // Clearing to 0 makes every unloaded entry a "hold PC" jump.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // The read port bypasses nothing, so a read of the entry being written
   // shows the old value until the write edge has passed.
   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/jump_lut_loader.sv
// ---------------------------------------------------------------------------
// jump_lut_loader
//
// Loads an N-entry table of D-bit two's-complement jump offsets from a
// byte stream (LO byte then HI byte per entry) and serves combinational
// lookups from it at any time.
//
// Optional feature macro: JUMP_LUT_CHECKSUM_EN
//   When defined, a final byte is expected after the 2N data bytes and is
//   compared against the XOR of all data bytes; a mismatch sets err.
//   When undefined, err is tied to 0 and the load ends after 2N bytes.
//
// Ports:
//   clk        : clock
//   reset      : asynchronous active-high reset
//   start      : one-cycle pulse, begins a load (ignored while busy)
//   in_valid   : in_data carries a byte
//   in_data    : load byte stream
//   in_ready   : block accepts in_data this cycle
//   rd_addr    : lookup index
//   rd_target  : table entry at rd_addr
//   busy       : load in progress (same as in_ready)
//   done       : last load completed, held until next start
//   err        : last load failed its checksum
// ---------------------------------------------------------------------------
module jump_lut_loader
   import jump_lut_pkg::*;
#(
   parameter  int D  = DEFAULT_D,
   parameter  int N  = DEFAULT_N,
   localparam int AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   input  logic [AW-1:0] rd_addr,
   output logic [D-1:0]  rd_target,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

   lut_state_e    state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [7:0]    loByte_q, loByte_d;
   logic          accept;
   logic          wrEn;
   logic [D-1:0]  wrData;

`ifdef JUMP_LUT_CHECKSUM_EN
   logic [7:0]    csum_q, csum_d;
   logic          err_q, err_d;
`endif

   // The block can take a byte in every state that is still waiting for
   // part of the stream; busy is the same condition seen from outside.
`ifdef JUMP_LUT_CHECKSUM_EN
   assign in_ready = (state_q == ST_LO) || (state_q == ST_HI) || (state_q == ST_CHK);
`else
   assign in_ready = (state_q == ST_LO) || (state_q == ST_HI);
`endif
   assign busy   = in_ready;
   assign done   = (state_q == ST_DONE);
   assign accept = in_valid && in_ready;

`ifdef JUMP_LUT_CHECKSUM_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // HI byte bits above the target width are dropped by the truncating cast.
   assign wrData = D'(joinBytes(in_data, loByte_q));

   // Next-state logic: walk LO/HI pairs across the table, then optionally
   // check the trailing XOR byte. start is only honoured when not loading.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      loByte_d = loByte_q;
      wrEn     = 1'b0;
`ifdef JUMP_LUT_CHECKSUM_EN
      csum_d   = csum_q;
      err_d    = err_q;
`endif

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_LO;
               idx_d   = '0;
`ifdef JUMP_LUT_CHECKSUM_EN
               csum_d  = '0;
               err_d   = 1'b0;
`endif
            end
         end

         ST_LO: begin
            if (accept) begin
               loByte_d = in_data;
               state_d  = ST_HI;
`ifdef JUMP_LUT_CHECKSUM_EN
               csum_d   = csum_q ^ in_data;
`endif
            end
         end

         ST_HI: begin
            if (accept) begin
               wrEn = 1'b1;
`ifdef JUMP_LUT_CHECKSUM_EN
               csum_d = csum_q ^ in_data;
`endif
               if (idx_q == LAST_IDX) begin
`ifdef JUMP_LUT_CHECKSUM_EN
                  state_d = ST_CHK;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = ST_LO;
               end
            end
         end

`ifdef JUMP_LUT_CHECKSUM_EN
         ST_CHK: begin
            if (accept) begin
               err_d   = (in_data != csum_q);
               state_d = ST_DONE;
            end
         end
`endif

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset abandons any load in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         loByte_q <= '0;
`ifdef JUMP_LUT_CHECKSUM_EN
         csum_q   <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         loByte_q <= loByte_d;
`ifdef JUMP_LUT_CHECKSUM_EN
         csum_q   <= csum_d;
         err_q    <= err_d;
`endif
      end
   end

   jump_lut_regfile #(
      .D (D),
      .N (N)
   ) uRegfile (
      .clk       (clk),
      .reset     (reset),
      .we_i      (wrEn),
      .wr_addr_i (idx_q),
      .wr_data_i (wrData),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_target)
   );

endmodule

// File: tb/tb_jump_lut_loader.sv
// ---------------------------------------------------------------------------
// tb_jump_lut_loader
//
// Self-checking bench for jump_lut_loader. The reference model holds the
// table as whole jump-target values; the byte stream is derived from those
// values (with random junk in the unused HI bits), and a completed load
// makes the model table equal to the values that were sent.
// Honours JUMP_LUT_CHECKSUM_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_jump_lut_loader;

   localparam int D  = 12;
   localparam int N  = 32;
   localparam int AW = 5;
`ifdef JUMP_LUT_CHECKSUM_EN
   localparam int CSUM = 1;
`else
   localparam int CSUM = 0;
`endif
   localparam int NBYTES = 2 * N + CSUM;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic [AW-1:0] rd_addr;
   logic [D-1:0]  rd_target;
   logic          busy;
   logic          done;
   logic          err;

   int testsRun    = 0;
   int testsFailed = 0;

   // Reference model: table contents as whole values.
   logic [D-1:0] expTbl  [N];
   logic [D-1:0] stimTbl [N];
   logic [7:0]   byteQ [$];

   // Observations collected while streaming.
   int           accepted;
   bit           busyDropped;
   bit           doneEarly;
   logic         doneAfter;
   logic [D-1:0] watchOld;
   logic [D-1:0] watchNew;

   jump_lut_loader #(
      .D (D),
      .N (N)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .rd_addr   (rd_addr),
      .rd_target (rd_target),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Serialise stimTbl: LO byte, then HI byte with random junk above the
   // target width, then (if enabled) the XOR of every data byte sent.
   task automatic buildStream(input bit corrupt);
      logic [7:0] lo;
      logic [7:0] hi;
      logic [7:0] xorSum;
      logic [3:0] junk;
      byteQ.delete();
      xorSum = 8'h00;
      for (int e = 0; e < N; e++) begin
         junk = 4'($urandom_range(0, 15));
         lo   = stimTbl[e][7:0];
         hi   = {junk, stimTbl[e][11:8]};
         byteQ.push_back(lo);
         byteQ.push_back(hi);
         xorSum = xorSum ^ lo ^ hi;
      end
      xorSum = xorSum ^ {7'b0, corrupt};
      if (CSUM == 1) byteQ.push_back(xorSum);
   endtask

   task automatic randomTable();
      for (int e = 0; e < N; e++) stimTbl[e] = 12'($urandom);
   endtask

   task automatic pulseStart();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Drive byteQ. validMode 0: always valid, 1: toggling, 2: random.
   // startAt pulses start on that stream cycle; watchByte records rd_target
   // around the acceptance of that byte; stopAfter limits accepted bytes.
   task automatic applyStimulus(input int validMode, input int startAt,
                                input int watchByte, input int stopAfter);
      int  total;
      int  cycles;
      bit  acc;
      total       = (stopAfter >= 0) ? stopAfter : byteQ.size();
      accepted    = 0;
      cycles      = 0;
      busyDropped = 0;
      doneEarly   = 0;
      while (accepted < total && cycles < 2000) begin
         @(negedge clk);
         case (validMode)
            0:       in_valid = 1'b1;
            1:       in_valid = (cycles % 2 == 0);
            default: in_valid = 1'($urandom_range(0, 1));
         endcase
         in_data = in_valid ? byteQ[accepted] : 8'($urandom);
         start   = (cycles == startAt);
         #1;
         if (!busy) busyDropped = 1;
         if (done) doneEarly = 1;
         acc = in_valid && in_ready;
         if (acc && accepted == watchByte) watchOld = rd_target;
         @(posedge clk);
         #1;
         start = 1'b0;
         if (acc) begin
            if (accepted == watchByte) watchNew = rd_target;
            accepted++;
         end
         cycles++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      #1 doneAfter = done;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      testsRun++;
      if ({in_ready, busy, done, err} !== 4'b0000) begin
         testsFailed++;
         $display("[TB] FAIL reset_outputs: got rdy/busy/done/err=%b expected 0000",
                  {in_ready, busy, done, err});
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int a = 0; a < N; a++) begin
         expTbl[a] = '0;
         @(negedge clk);
         rd_addr = AW'(a);
         #1;
         testsRun++;
         if (rd_target !== expTbl[a]) begin
            testsFailed++;
            $display("[TB] FAIL reset_entry[%0d]: got %h expected %h", a, rd_target, expTbl[a]);
         end
      end
   endtask

   task automatic test_directed_load();
      for (int e = 0; e < N; e++) stimTbl[e] = '0;
      stimTbl[0] = 12'hFFB;
      stimTbl[1] = 12'h014;
      stimTbl[2] = 12'hFFF;
      buildStream(1'b0);
      pulseStart();
      applyStimulus(0, -1, -1, -1);
      testsRun++;
      if (accepted !== NBYTES) begin
         testsFailed++;
         $display("[TB] FAIL directed_bytes: got %0d expected %0d", accepted, NBYTES);
      end
      testsRun++;
      if (doneEarly || doneAfter !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL directed_done_timing: got early=%0d after=%b expected 0/1",
                  doneEarly, doneAfter);
      end
      testsRun++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL directed_err_busy: got err=%b busy=%b expected 0/0", err, busy);
      end
      repeat (3) @(negedge clk);
      testsRun++;
      if (done !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL directed_done_held: got %b expected 1", done);
      end
      for (int e = 0; e < N; e++) expTbl[e] = stimTbl[e];
      for (int a = 0; a < N; a++) begin
         @(negedge clk);
         rd_addr = AW'(a);
         #1;
         testsRun++;
         if (rd_target !== expTbl[a]) begin
            testsFailed++;
            $display("[TB] FAIL directed_entry[%0d]: got %h expected %h", a, rd_target, expTbl[a]);
         end
      end
   endtask

   task automatic test_toggle_with_start();
      buildStream(1'b0);
      pulseStart();
      applyStimulus(1, 21, -1, -1);
      testsRun++;
      if (accepted !== NBYTES) begin
         testsFailed++;
         $display("[TB] FAIL toggle_bytes: got %0d expected %0d", accepted, NBYTES);
      end
      testsRun++;
      if (busyDropped) begin
         testsFailed++;
         $display("[TB] FAIL toggle_busy: got busy low mid-load expected high throughout");
      end
      testsRun++;
      if (doneEarly || doneAfter !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL toggle_done_timing: got early=%0d after=%b expected 0/1",
                  doneEarly, doneAfter);
      end
      for (int a = 0; a < N; a++) begin
         @(negedge clk);
         rd_addr = AW'(a);
         #1;
         testsRun++;
         if (rd_target !== expTbl[a]) begin
            testsFailed++;
            $display("[TB] FAIL toggle_entry[%0d]: got %h expected %h", a, rd_target, expTbl[a]);
         end
      end
   endtask

   task automatic test_reset_midload();
      randomTable();
      buildStream(1'b0);
      pulseStart();
      applyStimulus(0, -1, -1, 10);
      @(negedge clk);
      reset = 1'b1;
      rd_addr = AW'(0);
      #1;
      testsRun++;
      if ({in_ready, busy, done, err} !== 4'b0000) begin
         testsFailed++;
         $display("[TB] FAIL midreset_outputs: got rdy/busy/done/err=%b expected 0000",
                  {in_ready, busy, done, err});
      end
      @(negedge clk);
      reset = 1'b0;
      for (int a = 0; a < N; a++) begin
         expTbl[a] = '0;
         @(negedge clk);
         rd_addr = AW'(a);
         #1;
         testsRun++;
         if (rd_target !== expTbl[a]) begin
            testsFailed++;
            $display("[TB] FAIL midreset_entry[%0d]: got %h expected %h", a, rd_target, expTbl[a]);
         end
      end
      randomTable();
      buildStream(1'b0);
      pulseStart();
      applyStimulus(2, -1, -1, -1);
      testsRun++;
      if (accepted !== NBYTES || doneAfter !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL midreset_reload: got bytes=%0d done=%b expected %0d/1",
                  accepted, doneAfter, NBYTES);
      end
      for (int e = 0; e < N; e++) expTbl[e] = stimTbl[e];
      for (int a = 0; a < N; a++) begin
         @(negedge clk);
         rd_addr = AW'(a);
         #1;
         testsRun++;
         if (rd_target !== expTbl[a]) begin
            testsFailed++;
            $display("[TB] FAIL reload_entry[%0d]: got %h expected %h", a, rd_target, expTbl[a]);
         end
      end
   endtask

   task automatic test_read_during_write();
      logic [D-1:0] oldVal;
      oldVal = expTbl[5];
      randomTable();
      stimTbl[5] = oldVal ^ 12'hA5A;
      buildStream(1'b0);
      @(negedge clk);
      rd_addr = AW'(5);
      pulseStart();
      // Byte 11 is the HI byte of entry 5.
      applyStimulus(0, -1, 11, -1);
      testsRun++;
      if (watchOld !== oldVal) begin
         testsFailed++;
         $display("[TB] FAIL rdw_old: got %h expected %h", watchOld, oldVal);
      end
      testsRun++;
      if (watchNew !== stimTbl[5]) begin
         testsFailed++;
         $display("[TB] FAIL rdw_new: got %h expected %h", watchNew, stimTbl[5]);
      end
      for (int e = 0; e < N; e++) expTbl[e] = stimTbl[e];
   endtask

   task automatic test_random_loads();
      for (int it = 0; it < 4; it++) begin
         randomTable();
         buildStream(1'b0);
         pulseStart();
         applyStimulus(2, -1, -1, -1);
         testsRun++;
         if (accepted !== NBYTES || doneEarly || doneAfter !== 1'b1 || err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL random_load[%0d]: got bytes=%0d early=%0d done=%b err=%b expected %0d/0/1/0",
                     it, accepted, doneEarly, doneAfter, err, NBYTES);
         end
         for (int e = 0; e < N; e++) expTbl[e] = stimTbl[e];
         for (int a = 0; a < N; a++) begin
            @(negedge clk);
            rd_addr = AW'(a);
            #1;
            testsRun++;
            if (rd_target !== expTbl[a]) begin
               testsFailed++;
               $display("[TB] FAIL random_entry[%0d][%0d]: got %h expected %h",
                        it, a, rd_target, expTbl[a]);
            end
         end
      end
   endtask

`ifdef JUMP_LUT_CHECKSUM_EN
   task automatic test_checksum();
      randomTable();
      buildStream(1'b0);
      pulseStart();
      applyStimulus(0, -1, -1, -1);
      testsRun++;
      if (err !== 1'b0 || doneAfter !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL csum_good: got err=%b done=%b expected 0/1", err, doneAfter);
      end
      randomTable();
      buildStream(1'b1);
      pulseStart();
      applyStimulus(2, -1, -1, -1);
      repeat (2) @(negedge clk);
      testsRun++;
      if (err !== 1'b1 || done !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL csum_bad: got err=%b done=%b expected 1/1", err, done);
      end
      for (int e = 0; e < N; e++) expTbl[e] = stimTbl[e];
      for (int a = 0; a < N; a++) begin
         @(negedge clk);
         rd_addr = AW'(a);
         #1;
         testsRun++;
         if (rd_target !== expTbl[a]) begin
            testsFailed++;
            $display("[TB] FAIL csum_bad_entry[%0d]: got %h expected %h", a, rd_target, expTbl[a]);
         end
      end
      randomTable();
      buildStream(1'b0);
      pulseStart();
      testsRun++;
      if (err !== 1'b0 || done !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL csum_clear_on_start: got err=%b done=%b expected 0/0", err, done);
      end
      applyStimulus(0, -1, -1, -1);
      for (int e = 0; e < N; e++) expTbl[e] = stimTbl[e];
   endtask
`endif

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      rd_addr  = '0;
      test_reset();
      test_directed_load();
      test_toggle_with_start();
      test_reset_midload();
      test_read_during_write();
      test_random_loads();
`ifdef JUMP_LUT_CHECKSUM_EN
      test_checksum();
`endif
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/jump_lut_loader.md
JUMP_LUT_LOADER -- requirements
Module: jump_lut_loader

Interface
- REQ-001 The block SHALL have parameter D, default 12, which is the jump-target width in bits (two's complement PC offset).
- REQ-002 The block SHALL have parameter N, default 32, which is the number of table entries; AW = $clog2(N).
- REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
- REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle pulse that begins a table load.
- REQ-006 The block SHALL have port in_valid, input, 1 bit: the load byte on in_data is valid.
- REQ-007 The block SHALL have port in_data, input, 8 bits: the load byte stream.
- REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
- REQ-009 The block SHALL have port rd_addr, input, AW bits: the lookup index.
- REQ-010 The block SHALL have port rd_target, output, D bits: the table entry at rd_addr.
- REQ-011 The block SHALL have port busy, output, 1 bit: a load is in progress.
- REQ-012 The block SHALL have port done, output, 1 bit: the last load completed.
- REQ-013 The block SHALL have port err, output, 1 bit: the last load failed its checksum (see Configuration).

Function
- REQ-014 A byte SHALL be accepted only on a cycle with in_valid && in_ready; on all other cycles the block SHALL ignore in_data.
- REQ-015 The FSM SHALL have states IDLE, LO, HI, CHK and DONE.
- REQ-016 In IDLE or DONE, start SHALL move the FSM to LO, set the entry index to 0, and clear done and err.
- REQ-017 In LO, an accepted byte SHALL be latched as target[7:0] and the FSM SHALL move to HI.
- REQ-018 In HI, an accepted byte SHALL write table[idx] = {in_data[D-9:0], lo_byte}; in_data bits above D-9 SHALL be ignored.
- REQ-019 After an accepted HI byte with idx < N-1, idx SHALL increment and the FSM SHALL return to LO.
- REQ-020 After an accepted HI byte with idx == N-1, the FSM SHALL go to CHK, or to DONE when the checksum feature is compiled out.
- REQ-021 in_ready SHALL be 1 exactly in LO, HI and CHK; busy SHALL equal in_ready.
- REQ-022 done SHALL be 1 in DONE and held there until the next start.
- REQ-023 done SHALL rise on the cycle after the final accepted byte.
- REQ-024 start SHALL be ignored while busy.
- REQ-025 rd_target SHALL be combinational from table[rd_addr].
- REQ-026 A read of the entry being written SHALL return the old value in that cycle and the new value from the next cycle.
- REQ-027 Reads SHALL be valid in every state, including mid-load; unloaded entries keep their previous contents.
- REQ-028 Each table entry write SHALL take one cycle per byte; the minimum load time SHALL be 2N accepted bytes (+1 with the checksum feature).

Reset
- REQ-029 On reset assertion, regardless of clock, the FSM SHALL go to IDLE and idx, lo_byte and the checksum SHALL clear to 0.
- REQ-030 On reset assertion, every table entry SHALL clear to 0 (hold PC).
- REQ-031 On reset assertion, in_ready, busy, done and err SHALL be 0 and rd_target SHALL be 0.
- REQ-032 Reset during a load SHALL abort it with no partial state retained.

Configuration
- REQ-033 With macro JUMP_LUT_CHECKSUM_EN defined, the block SHALL keep a running XOR of all 2N accepted data bytes.
- REQ-034 With JUMP_LUT_CHECKSUM_EN defined, the byte accepted in CHK SHALL be compared to the running XOR, err SHALL be set on mismatch, and the FSM SHALL go to DONE.
- REQ-035 With JUMP_LUT_CHECKSUM_EN defined, err SHALL be sticky until the next start or reset, and table contents SHALL be kept regardless of err.
- REQ-036 Without JUMP_LUT_CHECKSUM_EN, the CHK state and checksum register SHALL be absent and err SHALL be tied to 0.

Structure
- REQ-037 Package jump_lut_pkg SHALL hold the FSM state enum, the default D and N constants, and the byte-split helper constants.
- REQ-038 Table storage SHALL be the sub-module jump_lut_regfile: N x D, one synchronous write port, one combinational read port, async clear.

Verification
- REQ-039 After reset, sweeping rd_addr 0..31 -> rd_target = 0 every time; in_ready, busy, done and err all 0.
- REQ-040 Load entry0 = 0xFFB (-5), entry1 = 0x014 (+20), entry2 = 0xFFF (-1), rest 0, with in_valid always 1 -> done one cycle after byte 64 (65 with checksum); reads return 0xFFB, 0x014, 0xFFF, 0.
- REQ-041 The same load with in_valid toggling 1/0 every cycle and a start pulse mid-load -> identical table, start ignored, busy high throughout the load.
- REQ-042 Reset asserted after 10 accepted bytes -> immediate IDLE; all entries 0 including entry0..4; a subsequent full load succeeds.
- REQ-043 With JUMP_LUT_CHECKSUM_EN defined, a correct XOR byte -> err = 0; a wrong XOR byte (correct ^ 0x01) -> err = 1, done = 1, table still loaded; the next start clears err.
- REQ-044 Drive rd_addr = 5 while entry 5's HI byte is accepted -> the old value in that cycle, the new value on the next cycle.
